// File: rtl/opl3_host_bus_if.sv
// Host-bus front end for a set of OPL3 register files: registers the async host pins,
// tracks a per-chip address latch, queues register writes in an FWFT FIFO and serves status reads.
module opl3_host_bus_if #(
  parameter int NUM_CHIPS  = 1,
  parameter int CHIP_W     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic                   clk_host,
  input  logic                   reset,
  input  logic [NUM_CHIPS-1:0]   cs_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic [1:0]             address,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  input  logic [8*NUM_CHIPS-1:0] status_in,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [CHIP_W-1:0]      cmd_chip,
  output logic [8:0]             cmd_addr,
  output logic [7:0]             cmd_data,
  output logic [LVL_W-1:0]       fifo_level,
  output logic                   overflow,
  output logic                   bus_error,
  input  logic                   clear_errors
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CHIP_W + 9 + 8;
  localparam int SEL_W = $clog2(NUM_CHIPS + 1) + 1;

  // Command stream: the head is offered while cmd_valid is high and leaves the FIFO
  // on any cycle where cmd_valid && cmd_ready; the head is stable until then.

  logic [NUM_CHIPS-1:0] cs_p1_n;
  logic                 rd_p1_n;
  logic                 wr_p1_n;
  logic [1:0]           address_p1;
  logic [7:0]           din_p1;
  logic                 wr_act;
  logic                 wr_act_q;
  logic                 wr_evt;

  always_ff @(posedge clk_host) begin
    if (reset) begin
      cs_p1_n    <= '1;
      rd_p1_n    <= 1'b1;
      wr_p1_n    <= 1'b1;
      address_p1 <= '0;
      din_p1     <= '0;
      wr_act_q   <= 1'b0;
    end else begin
      cs_p1_n    <= cs_n;
      rd_p1_n    <= rd_n;
      wr_p1_n    <= wr_n;
      address_p1 <= address;
      din_p1     <= din;
      wr_act_q   <= wr_act;
    end
  end

  // The read strobe is registered only to keep the bus sampling symmetric; decode ignores it.
  logic unused_rd;
  assign unused_rd = rd_p1_n;

  assign wr_act = (cs_p1_n != '1) && !wr_p1_n;
  assign wr_evt = wr_act && !wr_act_q;

  logic [8:0]        addr_latch [NUM_CHIPS];
  logic [SEL_W-1:0]  n_sel;
  logic [CHIP_W-1:0] sel_chip;
  logic [8:0]        sel_latch;
  logic [7:0]        sel_status;
  logic              one_sel;
  logic              multi_sel;

  always_comb begin
    n_sel      = '0;
    sel_chip   = '0;
    sel_latch  = '0;
    sel_status = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (!cs_p1_n[i]) begin
        n_sel      = n_sel + SEL_W'(1);
        sel_chip   = CHIP_W'(i);
        sel_latch  = addr_latch[i];
        sel_status = status_in[8*i +: 8];
      end
    end
  end

  assign one_sel   = (n_sel == SEL_W'(1));
  assign multi_sel = (n_sel > SEL_W'(1));

  always_ff @(posedge clk_host) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHIPS; i++) addr_latch[i] <= '0;
    end else if (wr_evt && one_sel && !address_p1[0]) begin
      for (int i = 0; i < NUM_CHIPS; i++)
        if (!cs_p1_n[i]) addr_latch[i] <= {address_p1[1], din_p1};
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;

  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign push_req = wr_evt && one_sel && address_p1[0];
  assign pop      = cmd_valid && cmd_ready;
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk_host) begin
    if (push) mem[wr_ptr] <= {sel_chip, sel_latch, din_p1};
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign cmd_valid  = (level != '0);
  assign fifo_level = level;
  assign {cmd_chip, cmd_addr, cmd_data} = mem[rd_ptr];

  // A set in the same cycle as clear_errors wins.
  always_ff @(posedge clk_host) begin
    if (reset) begin
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clear_errors)        overflow <= 1'b0;
      if (wr_evt && multi_sel)      bus_error <= 1'b1;
      else if (clear_errors)        bus_error <= 1'b0;
    end
  end

  always_ff @(posedge clk_host) begin
    if (reset)                           dout <= 8'hFF;
    else if (one_sel && address_p1 == 2'b00) dout <= sel_status;
    else                                 dout <= 8'hFF;
  end

endmodule

// File: tb/tb_opl3_host_bus_if.sv
// Bench for opl3_host_bus_if: directed scenarios followed by randomized bus traffic,
// checked against a queue-based model of the command stream and per-chip latches.
module tb_opl3_host_bus_if;

  localparam int NUM_CHIPS  = 2;
  localparam int CHIP_W     = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = 5;

  logic                   clk_host = 1'b0;
  logic                   reset;
  logic [NUM_CHIPS-1:0]   cs_n;
  logic                   rd_n;
  logic                   wr_n;
  logic [1:0]             address;
  logic [7:0]             din;
  logic [7:0]             dout;
  logic [8*NUM_CHIPS-1:0] status_in;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [CHIP_W-1:0]      cmd_chip;
  logic [8:0]             cmd_addr;
  logic [7:0]             cmd_data;
  logic [LVL_W-1:0]       fifo_level;
  logic                   overflow;
  logic                   bus_error;
  logic                   clear_errors;

  always #5 clk_host = ~clk_host;

  opl3_host_bus_if #(
    .NUM_CHIPS(NUM_CHIPS), .CHIP_W(CHIP_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk_host(clk_host), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .address(address), .din(din), .dout(dout), .status_in(status_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chip(cmd_chip),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .fifo_level(fifo_level),
    .overflow(overflow), .bus_error(bus_error), .clear_errors(clear_errors)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: expected command queue {chip, addr9, data8}, latches, sticky flags.
  logic [CHIP_W+16:0] exp_q[$];
  logic [8:0]         m_latch [NUM_CHIPS];
  logic               m_ovf;
  logic               m_berr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    logic [CHIP_W+16:0] h;
    check($sformatf("%s.level", tag), 32'(fifo_level), 32'(exp_q.size()));
    check($sformatf("%s.valid", tag), 32'(cmd_valid), 32'(exp_q.size() != 0));
    check($sformatf("%s.overflow", tag), 32'(overflow), 32'(m_ovf));
    check($sformatf("%s.bus_error", tag), 32'(bus_error), 32'(m_berr));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check($sformatf("%s.head_chip", tag), 32'(cmd_chip), 32'(h[CHIP_W+16:17]));
      check($sformatf("%s.head_addr", tag), 32'(cmd_addr), 32'(h[16:8]));
      check($sformatf("%s.head_data", tag), 32'(cmd_data), 32'(h[7:0]));
    end
  endtask

  function automatic int count_low(input logic [NUM_CHIPS-1:0] cs);
    int n = 0;
    for (int i = 0; i < NUM_CHIPS; i++) if (!cs[i]) n++;
    return n;
  endfunction

  function automatic int low_index(input logic [NUM_CHIPS-1:0] cs);
    int k = 0;
    for (int i = 0; i < NUM_CHIPS; i++) if (!cs[i]) k = i;
    return k;
  endfunction

  // One host write strobe held low for two clocks; pop_same raises cmd_ready for the
  // single clock on which the write lands in the FIFO.
  task automatic bus_write(input logic [NUM_CHIPS-1:0] cs, input logic [1:0] a,
                           input logic [7:0] d, input bit pop_same);
    int n, k;
    @(negedge clk_host);
    cs_n = cs; address = a; din = d; wr_n = 1'b0;
    @(negedge clk_host);
    if (pop_same) cmd_ready = 1'b1;
    @(negedge clk_host);
    cmd_ready = 1'b0; wr_n = 1'b1; cs_n = '1;
    @(negedge clk_host);
    n = count_low(cs);
    k = low_index(cs);
    if (pop_same && exp_q.size() != 0) void'(exp_q.pop_front());
    if (n > 1) m_berr = 1'b1;
    else if (n == 1) begin
      if (!a[0]) m_latch[k] = {a[1], d};
      else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({CHIP_W'(k), m_latch[k], d});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic pop_one();
    @(negedge clk_host);
    cmd_ready = 1'b1;
    @(negedge clk_host);
    cmd_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic bus_read(input logic [NUM_CHIPS-1:0] cs, input logic [1:0] a,
                          input logic [8*NUM_CHIPS-1:0] st);
    logic [7:0] exp;
    @(negedge clk_host);
    status_in = st; cs_n = cs; address = a; rd_n = 1'b0;
    @(negedge clk_host);
    check("dout_one_clk", 32'(dout), 32'hFF);
    @(negedge clk_host);
    if (count_low(cs) == 1 && a == 2'b00) exp = st[8*low_index(cs) +: 8];
    else exp = 8'hFF;
    check("dout", 32'(dout), 32'(exp));
    rd_n = 1'b1; cs_n = '1; address = 2'b00;
    @(negedge clk_host);
  endtask

  task automatic clear_pulse();
    @(negedge clk_host);
    clear_errors = 1'b1;
    @(negedge clk_host);
    clear_errors = 1'b0;
    m_ovf = 1'b0; m_berr = 1'b0;
  endtask

  function automatic logic [NUM_CHIPS-1:0] rand_cs();
    int r = $urandom_range(0, 9);
    if (r < 4) return 2'b10;
    if (r < 8) return 2'b01;
    if (r == 8) return 2'b00;
    return 2'b11;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs_n = '1; rd_n = 1'b1; wr_n = 1'b1; address = 2'b00; din = 8'h00;
    status_in = 16'h0000; cmd_ready = 1'b0; clear_errors = 1'b0;
    for (int i = 0; i < NUM_CHIPS; i++) m_latch[i] = '0;
    m_ovf = 1'b0; m_berr = 1'b0;
    repeat (3) @(negedge clk_host);
    reset = 1'b0;
    @(negedge clk_host);
    check("reset_dout", 32'(dout), 32'hFF);
    check_state("reset");

    // Address write then data write produces a single command.
    bus_write(2'b10, 2'b00, 8'hB4, 1'b0);
    check_state("addr_only");
    bus_write(2'b10, 2'b01, 8'h2A, 1'b0);
    check_state("first_cmd");
    pop_one();
    check_state("first_pop");

    // Bank-1 address reused by three data writes.
    bus_write(2'b10, 2'b10, 8'h05, 1'b0);
    bus_write(2'b10, 2'b01, 8'h11, 1'b0);
    bus_write(2'b10, 2'b01, 8'h22, 1'b0);
    bus_write(2'b10, 2'b01, 8'h33, 1'b0);
    check_state("three_cmds");
    for (int i = 0; i < 3; i++) begin
      pop_one();
      check_state("drain3");
    end

    // Seventeen data writes into a 16-deep FIFO.
    bus_write(2'b01, 2'b00, 8'h40, 1'b0);
    for (int i = 0; i < 17; i++) bus_write(2'b01, 2'b01, 8'($urandom_range(0, 255)), 1'b0);
    check_state("full_ovf");
    clear_pulse();
    check_state("ovf_cleared");

    // Push into a full FIFO together with a pop.
    bus_write(2'b01, 2'b01, 8'hE7, 1'b1);
    check_state("full_push_pop");

    // Status readback and multi-select write.
    bus_read(2'b01, 2'b00, {8'hC0, 8'h60});
    bus_read(2'b10, 2'b00, {8'hC0, 8'h60});
    bus_read(2'b10, 2'b01, {8'hC0, 8'h60});
    bus_read(2'b00, 2'b00, {8'hC0, 8'h60});
    bus_read(2'b11, 2'b00, {8'hC0, 8'h60});
    bus_write(2'b00, 2'b01, 8'h99, 1'b0);
    check_state("bus_err");
    clear_pulse();
    while (exp_q.size() != 0) pop_one();
    check_state("drained");

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      int op = $urandom_range(0, 9);
      if (op <= 5)
        bus_write(rand_cs(), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0));
      else if (op <= 7) pop_one();
      else if (op == 8)
        bus_read(rand_cs(), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
      else clear_pulse();
      check_state("rnd");
    end

    // Reset mid-operation with five queued commands and a selected status read.
    while (exp_q.size() != 0) pop_one();
    bus_write(2'b10, 2'b10, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) bus_write(2'b10, 2'b01, 8'(8'h50 + i), 1'b0);
    check_state("pre_reset");
    @(negedge clk_host);
    status_in = 16'h12AB; cs_n = 2'b10; address = 2'b00; rd_n = 1'b0;
    repeat (2) @(negedge clk_host);
    check("pre_reset_dout", 32'(dout), 32'hAB);
    reset = 1'b1;
    @(negedge clk_host);
    exp_q.delete();
    for (int i = 0; i < NUM_CHIPS; i++) m_latch[i] = '0;
    m_ovf = 1'b0; m_berr = 1'b0;
    check("reset_mid_dout", 32'(dout), 32'hFF);
    check_state("reset_mid");
    reset = 1'b0; cs_n = '1; rd_n = 1'b1;
    @(negedge clk_host);
    bus_write(2'b10, 2'b01, 8'h77, 1'b0);
    check_state("latch_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
